blink_timer_bank: RTL
=====================

// Module: blink_timer_bank
// PURPOSE
//  Multi-channel programmable timer/LED driver for board-level status and blink outputs.
//  One shared prescaler turns clk into a slow tick (default 1 ms).
//  CH independent channels each count ticks up to a runtime-loadable period.
//  Per channel mode: off, toggle, one-shot or strobe; one-cycle expiry flag per channel.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency
//  TICK_HZ     1000        prescaler tick rate; PRE = CLK_HZ/TICK_HZ (integer, >=2)
//  CH          4           channel count, >=1
//  PW          16          period/counter width, in ticks
//  DEF_PERIOD  400         reset period of every channel, in ticks
//  DEF_MODE    2'b01       reset mode of every channel (TOGGLE -> 0.8 s blink at defaults)
// PORTS
//  clk        in   1     single clock
//  aclr       in   1     asynchronous, active-low reset
//  run        in   1     global enable for prescaler; 0 freezes all timing
//  wr_en      in   1     channel config write strobe
//  wr_ch      in   CHW   target channel, CHW = max(1, clogb2(CH-1))
//  wr_period  in   PW    new period in ticks
//  wr_mode    in   2     new mode: 00 OFF, 01 TOGGLE, 10 ONESHOT, 11 STROBE
//  out        out  CH    registered channel outputs (LED drive)
//  expire     out  CH    registered one-cycle pulse per period expiry
//  tick       out  1     prescaler tick, combinational, 1 cycle wide
// BEHAVIOUR
//  Reset (aclr=0, any time, async):
//   pre=0, all cnt=0, period=DEF_PERIOD, mode=DEF_MODE, out=0, expire=0.
//  Prescaler:
//   pre advances only when run=1; wraps PRE-1 -> 0.
//   tick = run & (pre==PRE-1).
//   run=0 holds pre and all channel state; no expiry possible.
//  Channel i, every edge, priority order:
//   1) wr_en & wr_ch==i: period<=wr_period, mode<=wr_mode, cnt<=0, expire<=0.
//      out<=1 if wr_mode==ONESHOT, else 0. Write wins over a same-edge expiry.
//   2) else tick & mode!=OFF & cnt==P-1, where P = (period==0) ? 1 : period:
//      cnt<=0, expire<=1 (high exactly one cycle).
//      TOGGLE:  out<=~out; full blink cycle = 2*P ticks.
//      ONESHOT: out<=0, mode<=OFF; exactly one expire pulse.
//      STROBE:  out<=1 for this one cycle only, then back to 0.
//   3) else tick & mode!=OFF: cnt<=cnt+1.
//   4) mode==OFF: cnt held 0, out=0, expire=0.
//   expire and STROBE out clear to 0 on every edge not covered by 1) or 2).
//  wr_ch >= CH: write ignored, no state change.
//  Latency: out/expire update on the same edge that consumes the expiring tick.
//  Period 0 behaves as period 1 (expiry every tick). cnt never exceeds P-1.
//  Period is PW bits, unsigned; no overflow, since cnt compares against P-1 before incrementing.
//  Mid-count period write restarts the count from 0; there is no partial-period carry-over.
// STRUCTURE
//  Shared header blink_defs.vh: mode constants MODE_OFF/TOGGLE/ONESHOT/STROBE, clogb2 function.
//  Sub-module tick_prescaler #(PRE): clk, aclr, run -> tick. Modulo counter with enable-gated wrap.
//  Channels: generate loop over CH; one cnt/period/mode/out/expire register set each.
// TESTING (CLK_HZ=10, TICK_HZ=1 -> PRE=10, CH=4, PW=8, DEF_PERIOD=3, DEF_MODE=TOGGLE)
//  Reset release, run=1:
//   first tick at cycle 10; out[3:0] 0->F at tick 3 (cycle 30), toggles every 30 cycles;
//   expire=F one cycle at each toggle.
//  run=0 for 25 cycles mid-count: tick, cnt, out frozen; resumes and expires exactly 25 cycles late.
//  Write ch1 ONESHOT period 2:
//   out[1]=1 next cycle; drops after 2 ticks with one expire[1] pulse; ch1 then OFF, no more pulses.
//  Write ch2 STROBE period 0: out[2] and expire[2] high one cycle on every tick (every 10 cycles).
//  Write ch0 on the edge where ch0 would expire: no expire[0], out[0]=0, cnt[0]=0.
//   Write wr_ch=5 (CHW=2 truncates to 1?) -> use CH=3 bench: wr_ch=3 ignored, all channels unchanged.
//  aclr pulse mid-period: all outputs 0 immediately (async); defaults restored; counting restarts from 0.

Source files
------------

// File: rtl/blink_timer_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : blink_timer_bank_pkg
//  Purpose  : Shared definitions for the blink timer bank. Holds the channel
//             mode encoding and the width helpers used to size the channel
//             select and prescaler counters.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package blink_timer_bank_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_TOGGLE  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_STROBE  = 2'b11
    } mode_t;

    // Number of bits needed to represent value (0 -> 0 bits).
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

    // Channel-select width: enough bits to address CH-1, never less than 1.
    function automatic int chw_of(input int ch);
        int w;
        w = clogb2(ch - 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blink_timer_bank_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : blink_timer_bank_prescaler
//  Purpose  : Shared prescaler. Modulo-PRE counter that advances only while
//             run is high and produces a one-cycle combinational tick on the
//             cycle before it wraps.
//  Ports    : clk  - clock
//             aclr - asynchronous active-low reset
//             run  - count enable; low freezes the counter and masks tick
//             tick - run & (count == PRE-1)
//  Revision : 1.0  initial release
// ============================================================================
module blink_timer_bank_prescaler #(
    parameter int PRE = 10
) (
    input  logic clk,
    input  logic aclr,
    input  logic run,
    output logic tick
);

    localparam int              c_prew = (PRE > 1) ? $clog2(PRE) : 1;
    localparam logic [c_prew-1:0] c_last = c_prew'(PRE - 1);

    logic [c_prew-1:0] r_pre;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_pre <= '0;
        end else if (run) begin
            if (r_pre == c_last) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign tick = run & (r_pre == c_last);

endmodule
`default_nettype wire

// File: rtl/blink_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module   : blink_timer_bank
//  Purpose  : Multi-channel programmable timer / LED driver. One shared
//             prescaler produces a slow tick; each channel counts ticks up to
//             its own runtime-loadable period and drives its output in OFF,
//             TOGGLE, ONESHOT or STROBE mode with a one-cycle expiry flag.
//  Ports    : clk       - clock
//             aclr      - asynchronous active-low reset
//             run       - global enable; low freezes all timing
//             wr_en     - channel configuration write strobe
//             wr_ch     - target channel (values >= CH are ignored)
//             wr_period - new period in ticks (0 behaves as 1)
//             wr_mode   - new mode (00 OFF, 01 TOGGLE, 10 ONESHOT, 11 STROBE)
//             out       - registered channel outputs
//             expire    - registered one-cycle expiry pulses
//             tick      - prescaler tick, combinational
//  Revision : 1.0  initial release
// ============================================================================
module blink_timer_bank
    import blink_timer_bank_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          TICK_HZ    = 1000,
    parameter int          CH         = 4,
    parameter int          PW         = 16,
    parameter int          DEF_PERIOD = 400,
    parameter logic [1:0]  DEF_MODE   = 2'b01,
    localparam int         CHW        = chw_of(CH)
) (
    input  logic            clk,
    input  logic            aclr,
    input  logic            run,
    input  logic            wr_en,
    input  logic [CHW-1:0]  wr_ch,
    input  logic [PW-1:0]   wr_period,
    input  logic [1:0]      wr_mode,
    output logic [CH-1:0]   out,
    output logic [CH-1:0]   expire,
    output logic            tick
);

    localparam int c_pre = CLK_HZ / TICK_HZ;

    wire [CH-1:0] w_out_bits;
    wire [CH-1:0] w_expire_bits;

    blink_timer_bank_prescaler #(
        .PRE (c_pre)
    ) u_prescaler (
        .clk  (clk),
        .aclr (aclr),
        .run  (run),
        .tick (tick)
    );

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [PW-1:0] r_cnt;
        logic [PW-1:0] r_period;
        mode_t         r_mode;
        logic          r_out;
        logic          r_expire;
        logic          w_sel;
        logic [PW-1:0] w_last;

        // An out-of-range wr_ch matches no generated channel, so it is dropped.
        assign w_sel  = wr_en && (wr_ch == CHW'(i));
        // Period 0 is treated as period 1, i.e. the last count is 0.
        assign w_last = (r_period == '0) ? '0 : r_period - 1'b1;

        always_ff @(posedge clk or negedge aclr) begin
            if (!aclr) begin
                r_cnt    <= '0;
                r_period <= PW'(DEF_PERIOD);
                r_mode   <= mode_t'(DEF_MODE);
                r_out    <= 1'b0;
                r_expire <= 1'b0;
            end else begin
                r_expire <= 1'b0;
                if (w_sel) begin
                    // A write takes precedence over an expiry on the same edge.
                    r_period <= wr_period;
                    r_mode   <= mode_t'(wr_mode);
                    r_cnt    <= '0;
                    r_out    <= (mode_t'(wr_mode) == MODE_ONESHOT);
                end else if (r_mode == MODE_OFF) begin
                    r_cnt <= '0;
                    r_out <= 1'b0;
                end else if (tick && (r_cnt == w_last)) begin
                    r_cnt    <= '0;
                    r_expire <= 1'b1;
                    case (r_mode)
                        MODE_TOGGLE:  r_out <= ~r_out;
                        MODE_ONESHOT: begin
                            r_out  <= 1'b0;
                            r_mode <= MODE_OFF;
                        end
                        MODE_STROBE:  r_out <= 1'b1;
                        default:      r_out <= 1'b0;
                    endcase
                end else begin
                    if (tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // Strobe output is only ever high for the expiry cycle.
                    if (r_mode == MODE_STROBE) begin
                        r_out <= 1'b0;
                    end
                end
            end
        end

        assign w_out_bits[i]    = r_out;
        assign w_expire_bits[i] = r_expire;
    end

    assign out    = w_out_bits;
    assign expire = w_expire_bits;

endmodule
`default_nettype wire
